seg7_scan_driver: RTL and testbench

- Downstream consumer of the 32-bit score word: 8 packed 4-bit BCD digits, as two independent 4-digit groups (digits 7..4 and 3..0).
- Time-multiplexes the digits onto an 8-digit common-anode seven-segment display.
- Takes a frame-coherent snapshot of the score word so a display frame never mixes old and new digits.
- Blanks leading zeros per group on request.

---
 rtl/seg7_scan_driver.sv | 140 ++++++++++++++
 tb/tb_seg7_scan_driver.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : seg7_scan_driver
// Purpose  : Time-multiplexes a 32-bit word of eight packed 4-bit digits onto
//            an 8-digit common-anode seven-segment display.
//            - The word is sampled once per frame, so a frame never mixes old
//              and new digits.
//            - Optional leading-zero blanking is applied independently to the
//              two 4-digit groups (digits 7..4 and 3..0).
// Ports    : clk      - system clock
//            rst_n    - asynchronous active-low reset
//            data     - score word, digit k = data[4k+3:4k]
//            lz_blank - 1 = blank leading zeros within each group
//            dp_mask  - per-digit decimal points (only with SEG7_DP_EN)
//            an       - digit enables, active low
//            seg      - {dp,g,f,e,d,c,b,a}, active low
// Macro    : SEG7_DP_EN - adds dp_mask and a per-frame decimal-point snapshot
// Revision : 1.0 - initial release
// ============================================================================
module seg7_scan_driver #(
  parameter logic [15:0] SCAN_DIV = 16'd50000,
  parameter int          PRESC_W  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data,
  input  logic        lz_blank,
`ifdef SEG7_DP_EN
  input  logic [7:0]  dp_mask,
`endif
  output logic [7:0]  an,
  output logic [7:0]  seg
);

  localparam logic [PRESC_W-1:0] C_PRESC_MAX = PRESC_W'(SCAN_DIV - 16'd1);

  logic [PRESC_W-1:0] r_presc;
  logic [2:0]         r_idx;
  logic [31:0]        r_snap;
  logic               w_tick;
  logic [7:0]         w_zero;
  logic [7:0]         w_blank;
  logic [3:0]         w_digit;
  logic [6:0]         w_glyph;
  logic               w_dp_n;

  assign w_tick = (r_presc == C_PRESC_MAX);

  // Prescaler, digit index and frame snapshot. The snapshot is taken on the
  // same tick that wraps idx 7 -> 0, so digit 0 of the new frame already
  // shows the new word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
      r_idx   <= 3'd0;
      r_snap  <= 32'h0;
    end else begin
      if (w_tick) begin
        r_presc <= '0;
        r_idx   <= r_idx + 3'd1;
        if (r_idx == 3'd7) begin
          r_snap <= data;
        end
      end else begin
        r_presc <= r_presc + PRESC_W'(1);
      end
    end
  end

`ifdef SEG7_DP_EN
  logic [7:0] r_dp_snap;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dp_snap <= 8'h00;
    end else if (w_tick && (r_idx == 3'd7)) begin
      r_dp_snap <= dp_mask;
    end
  end

  assign w_dp_n = ~r_dp_snap[r_idx];
`else
  assign w_dp_n = 1'b1;
`endif

  // A digit is blanked when it and every higher digit of its own group are
  // zero; the lowest digit of each group always stays lit.
  genvar k;
  generate
    for (k = 0; k < 8; k++) begin : g_digit
      localparam int P = k % 4;
      localparam int G = k / 4;
      assign w_zero[k] = (r_snap[4*k +: 4] == 4'h0);
      if (P == 0) begin : g_lsd
        assign w_blank[k] = 1'b0;
      end else begin : g_upper
        assign w_blank[k] = lz_blank & (&w_zero[G*4+3 : G*4+P]);
      end
    end
  endgenerate

  assign w_digit = r_snap[{r_idx, 2'b00} +: 4];

  // Active-low glyphs {g,f,e,d,c,b,a}; illegal BCD values render as hex.
  always_comb begin
    w_glyph = 7'h7F;
    case (w_digit)
      4'h0: w_glyph = 7'h40;
      4'h1: w_glyph = 7'h79;
      4'h2: w_glyph = 7'h24;
      4'h3: w_glyph = 7'h30;
      4'h4: w_glyph = 7'h19;
      4'h5: w_glyph = 7'h12;
      4'h6: w_glyph = 7'h02;
      4'h7: w_glyph = 7'h78;
      4'h8: w_glyph = 7'h00;
      4'h9: w_glyph = 7'h10;
      4'hA: w_glyph = 7'h08;
      4'hB: w_glyph = 7'h03;
      4'hC: w_glyph = 7'h46;
      4'hD: w_glyph = 7'h21;
      4'hE: w_glyph = 7'h06;
      4'hF: w_glyph = 7'h0E;
      default: w_glyph = 7'h7F;
    endcase
  end

  // Registered outputs; the anode stays enabled on blanked digits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an  <= 8'hFF;
      seg <= 8'hFF;
    end else begin
      an  <= ~(8'b1 << r_idx);
      seg <= {w_dp_n, (w_blank[r_idx] ? 7'h7F : w_glyph)};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seg7_scan_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_seg7_scan_driver
// Purpose  : Self-checking bench for seg7_scan_driver with SCAN_DIV = 4.
//            Expected outputs come from a time-based model: the slot number
//            since reset gives the digit, the frame number gives which
//            sampled word is on display.
// Macro    : SEG7_DP_EN - connects dp_mask and models the decimal points
// Revision : 1.0 - initial release
// ============================================================================
module tb_seg7_scan_driver;

  localparam logic [15:0] SCAN_DIV = 16'd4;
  localparam int          DIV      = 4;
  localparam int          FRAME    = 8 * DIV;

  logic        clk      = 1'b0;
  logic        rst_n    = 1'b0;
  logic [31:0] data     = 32'h0;
  logic        lz_blank = 1'b0;
  logic [7:0]  dp_mask  = 8'h04;
  logic [7:0]  an;
  logic [7:0]  seg;

  int          vectors     = 0;
  int          miscompares = 0;
  int          k           = 0;    // clock edges since reset release
  logic [31:0] m_snap      = 32'h0;
  logic [7:0]  m_dp        = 8'h00;

  logic [6:0] glyph_tab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12,
                                 7'h02, 7'h78, 7'h00, 7'h10, 7'h08, 7'h03,
                                 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [6:0] glyph_exp [8];
  logic [6:0] lz_exp    [8];
  logic [6:0] hex_exp   [8];

  seg7_scan_driver #(
    .SCAN_DIV (SCAN_DIV),
    .PRESC_W  (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .data     (data),
    .lz_blank (lz_blank),
`ifdef SEG7_DP_EN
    .dp_mask  (dp_mask),
`endif
    .an       (an),
    .seg      (seg)
  );

  always #5 clk = ~clk;

  // Digit shown on the outputs after edge kk.
  function automatic int digit_of(input int kk);
    return ((kk - 1) / DIV) % 8;
  endfunction

  // Expected {an, seg} after edge kk given the word on display.
  function automatic logic [15:0] model(input int kk, input logic [31:0] s,
                                        input logic lz, input logic [7:0] dpm);
    int          d;
    int          pos;
    logic [3:0]  nib;
    logic [15:0] grp;
    logic        blank;
    logic [7:0]  one;
    logic [7:0]  e_an;
    logic        e_dp;
    d     = digit_of(kk);
    pos   = d % 4;
    nib   = 4'(s >> (4 * d));
    grp   = 16'(s >> (16 * (d / 4)));
    blank = lz && (pos != 0) && ((grp >> (4 * pos)) == 16'h0);
    one   = 8'h01;
    e_an  = ~(one << d);
`ifdef SEG7_DP_EN
    e_dp  = ~dpm[d];
`else
    e_dp  = 1'b1 | dpm[0];
`endif
    return {e_an, e_dp, (blank ? 7'h7F : glyph_tab[nib])};
  endfunction

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  task automatic check7(input string tag, input logic [6:0] obs, input logic [6:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h (edge %0d)", tag, obs, exp, k);
    end
  endtask

  // One clock: predict from the word currently on display, then record a
  // fresh sample if this edge closes a frame, then compare.
  task automatic step();
    logic [15:0] e;
    @(posedge clk);
    k++;
    e = model(k, m_snap, lz_blank, m_dp);
    if (k % FRAME == 0) begin
      m_snap = data;
      m_dp   = dp_mask;
    end
    #1;
    check8("an", an, e[15:8]);
    check8("seg", seg, e[7:0]);
  endtask

  task automatic random_data();
    for (int n = 0; n < 8; n++) begin
      data[4*n +: 4] = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
    end
  endtask

  initial begin
    glyph_exp = '{7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40};
    lz_exp    = '{7'h12, 7'h40, 7'h30, 7'h7F, 7'h40, 7'h7F, 7'h7F, 7'h7F};
    hex_exp   = '{7'h10, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h08, 7'h0E};

    // Reset state, then release away from a clock edge.
    data = 32'h0123_4567;
    #12;
    check8("rst_an", an, 8'hFF);
    check8("rst_seg", seg, 8'hFF);
    rst_n = 1'b1;
    #1;
    check8("rel_an", an, 8'hFF);

    // Frame 0 shows the reset snapshot; frame 1 shows 0123_4567.
    repeat (FRAME) step();
    repeat (FRAME) begin
      step();
      check7("glyph", seg[6:0], glyph_exp[digit_of(k)]);
    end

    // Frame coherence: change the word mid-frame.
    data = 32'h1111_1111;
    repeat (FRAME) step();
    repeat (14) step();
    data = 32'h2222_2222;
    repeat (FRAME - 14) begin
      step();
      if (digit_of(k) >= 4) check7("coh_old", seg[6:0], 7'h79);
    end
    repeat (FRAME) begin
      step();
      check7("coh_new", seg[6:0], 7'h24);
    end

    // Leading-zero blanking per group.
    lz_blank = 1'b1;
    data     = 32'h0000_0305;
    repeat (FRAME) step();
    repeat (FRAME) begin
      step();
      check7("lz", seg[6:0], lz_exp[digit_of(k)]);
    end

    // Hex digits and group boundary.
    data = 32'hFA00_0009;
    repeat (FRAME) step();
    repeat (FRAME) begin
      step();
      check7("hex", seg[6:0], hex_exp[digit_of(k)]);
    end

    // Randomized words and blanking mode.
    for (int i = 0; i < 12 * FRAME; i++) begin
      if ($urandom_range(0, 7) == 0) random_data();
      if ($urandom_range(0, 15) == 0) lz_blank = 1'($urandom);
      if ($urandom_range(0, 31) == 0) dp_mask = 8'($urandom);
      step();
    end

    // Mid-frame reset while digit 5 is scanning.
    dp_mask = 8'h04;
    for (int i = 0; i < 2 * FRAME && ((k / DIV) % 8) != 5; i++) step();
    #2;
    rst_n = 1'b0;
    #1;
    check8("mrst_an", an, 8'hFF);
    check8("mrst_seg", seg, 8'hFF);
    @(posedge clk);
    #2;
    rst_n  = 1'b1;
    k      = 0;
    m_snap = 32'h0;
    m_dp   = 8'h00;
    #1;
    check8("mrel_an", an, 8'hFF);
    lz_blank = 1'b0;
    random_data();
    repeat (DIV) begin
      step();
      check7("mrst_d0", seg[6:0], 7'h40);
    end
    repeat (3 * FRAME) step();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
